// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one i2c_core register port between NREQ requesters.
// Round-robin grant held for the whole tenure so that multi-access I2C
// transactions stay atomic. Each tenure is followed by one dead cycle.
// Optional idle-owner watchdog: define I2C_ARB_WATCHDOG_EN.
module i2c_bus_arbiter #(
   parameter int NREQ           = 2,
   parameter int ABUSWIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                        BUS_CLK,
   input  logic                        BUS_RST_N,
   input  logic [NREQ-1:0]             REQ,
   output logic [NREQ-1:0]             GNT,
   input  logic [NREQ*ABUSWIDTH-1:0]   REQ_ADD,
   input  logic [NREQ*8-1:0]           REQ_DATA_IN,
   input  logic [NREQ-1:0]             REQ_RD,
   input  logic [NREQ-1:0]             REQ_WR,
   output logic [7:0]                  REQ_DATA_OUT,
   input  logic [NREQ-1:0]             ERR_CLR,
   output logic [NREQ-1:0]             TIMEOUT_ERR,
   output logic [ABUSWIDTH-1:0]        IP_ADD,
   output logic [7:0]                  IP_DATA_IN,
   output logic                        IP_RD,
   output logic                        IP_WR,
   input  logic [7:0]                  IP_DATA_OUT
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

   state_t                state, state_nxt;
   logic [IW-1:0]         owner, owner_nxt;
   logic [IW-1:0]         ptr, ptr_nxt;
   logic [NREQ-1:0]       gnt_nxt;
   logic [NREQ-1:0]       blocked;
   logic [NREQ-1:0]       eligible;
   logic                  revoke;

   logic                  own_req, own_rd, own_wr, own_gnt;
   logic [ABUSWIDTH-1:0]  own_add;
   logic [7:0]            own_din;

   assign eligible     = REQ & ~blocked;
   assign REQ_DATA_OUT = IP_DATA_OUT;

   // State register: FSM state, registered grant, current owner and RR pointer
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state <= IDLE;
         GNT   <= '0;
         owner <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         GNT   <= gnt_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next-state: rotate eligibility so the first set bit is the next in RR order
   always_comb begin
      logic [2*NREQ-1:0] elig_rot;
      logic              found;
      int                sum;
      state_nxt = state;
      gnt_nxt   = GNT;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      found     = 1'b0;
      sum       = 0;
      elig_rot  = {eligible, eligible} >> ptr;
      case (state)
         IDLE: begin
            for (int j = 0; j < NREQ; j++) begin
               if (!found && elig_rot[j]) begin
                  found = 1'b1;
                  sum   = int'(ptr) + j;
                  if (sum >= NREQ) sum = sum - NREQ;
                  owner_nxt = IW'(sum);
                  gnt_nxt   = NREQ'(1) << sum;
                  ptr_nxt   = (sum + 1 >= NREQ) ? '0 : IW'(sum + 1);
                  state_nxt = GRANT;
               end
            end
         end
         GRANT: begin
            if (!own_req || revoke) begin
               gnt_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs: mux the owner's port onto i2c_core, forced to zero without a grant
   always_comb begin
      own_req = 1'b0;
      own_rd  = 1'b0;
      own_wr  = 1'b0;
      own_add = '0;
      own_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IW'(i)) begin
            own_req = REQ[i];
            own_rd  = REQ_RD[i];
            own_wr  = REQ_WR[i];
            own_add = REQ_ADD[i*ABUSWIDTH +: ABUSWIDTH];
            own_din = REQ_DATA_IN[i*8 +: 8];
         end
      end
      own_gnt    = |GNT;
      IP_ADD     = own_gnt ? own_add : '0;
      IP_DATA_IN = own_gnt ? own_din : '0;
      IP_RD      = own_gnt & own_rd;
      IP_WR      = own_gnt & own_wr;
   end

`ifdef I2C_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0]   wd_cnt;
   logic [NREQ-1:0] blocked_q;
   logic [NREQ-1:0] err_q;
   logic            fwd_strobe;
   logic            idle_owner;

   assign fwd_strobe  = own_gnt & (own_rd | own_wr);
   assign idle_owner  = (state == GRANT) && own_req && !fwd_strobe;
   // An owner that keeps REQ high without strobing for TIMEOUT_CYCLES is evicted
   assign revoke      = idle_owner && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign blocked     = blocked_q;
   assign TIMEOUT_ERR = err_q;

   // Watchdog: idle counter, eviction block until REQ drops, sticky error (set beats clear)
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         wd_cnt    <= '0;
         blocked_q <= '0;
         err_q     <= '0;
      end else begin
         if (idle_owner && !revoke) wd_cnt <= wd_cnt + 1'b1;
         else                       wd_cnt <= '0;
         blocked_q <= (blocked_q & REQ) | (revoke ? GNT : '0);
         err_q     <= (err_q & ~ERR_CLR) | (revoke ? GNT : '0);
      end
   end
`else
   logic unused_wd;

   assign revoke      = 1'b0;
   assign blocked     = '0;
   assign TIMEOUT_ERR = '0;
   assign unused_wd   = ^{ERR_CLR, TIMEOUT_CYCLES[0]};
`endif

endmodule
